fetchstage: RTL and testbench
=============================

Name: fetchstage

Overview:
- Instruction fetch stage. Sits directly upstream of memory stage 1 and supplies its inbound instruction word each cycle.
- Owns the program counter and issues word reads on the shared bus.
- Yields the bus whenever stage 1 flags a memory access cycle.
- Handles jump redirects with a flush, and stops fetching after a HALT instruction.

Parameters:
- RESET_PC, 32'h0000_0000, program counter value after reset (bits [1:0] must be 0).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- memory_access_cycle  input  1  from stage 1; its load/store owns the bus, so fetch must not drive it
- jump  input  1  redirect request from a later stage
- jump_address  input  32  redirect target; bits [1:0] ignored and forced to 0
- bus_data_in  input  32  read data from the bus interface
- bus_ready  input  1  bus read data valid for the outstanding fetch
- fetch_read  output  1  registered bus read request
- fetch_address  output  32  registered bus address, word aligned
- fetch_cycle_width  output  t_cycle_width  always the word width
- outbound_instruction  output  32  instruction to stage 1, registered
- outbound_pc  output  32  address of outbound_instruction
- halted  output  1  high once a HALT has been forwarded

Behaviour:
- Reset (reset low, asynchronous):
  - pc=RESET_PC, state=ISSUE
  - fetch_read=0, fetch_address=0
  - outbound_instruction={OPCODE_NOP,27'h0}, outbound_pc=0
  - halted=0
  - Reset mid-fetch abandons the request; any late bus_ready is ignored.
- Default every cycle: outbound_instruction=NOP, outbound_pc unchanged, unless a fetch completes.
- ISSUE state:
  - memory_access_cycle=1: fetch_read<=0, stay in ISSUE.
  - Otherwise: fetch_read<=1, fetch_address<=pc, go to WAIT.
- WAIT state, bus_ready=1 and jump=0:
  - outbound_instruction<=bus_data_in, outbound_pc<=pc, pc<=pc+4.
  - If the fetched opcode is HALT: fetch_read<=0, go to HALTED.
  - Else if memory_access_cycle=0: re-issue at pc+4 on the same edge and stay in WAIT. A zero-wait bus therefore gives one instruction per cycle.
  - Else: fetch_read<=0, go to ISSUE.
- WAIT state, bus_ready=0, memory_access_cycle=1: abandon the request (fetch_read<=0), keep pc, go to ISSUE. The same pc is refetched once the bus is free.
- Jump, in ISSUE or WAIT, has top priority:
  - pc<={jump_address[31:2],2'b00}, fetch_read<=0, outbound NOP, go to ISSUE.
  - Any bus_ready in that same cycle is discarded.
  - Jump together with memory_access_cycle: jump still redirects, and no issue happens that cycle.
- HALTED state:
  - fetch_read=0, halted=1, output NOP forever.
  - jump is ignored; only reset exits.
- Arithmetic: pc is a 32-bit increment by 4. 32'hFFFF_FFFC wraps to 0.
- Latency: first instruction appears at the outputs 2 cycles after reset release with a zero-wait bus (cycle 1 issue, cycle 2 capture). Each wait state adds 1 cycle.
- fetch_cycle_width is constant at the word encoding.

Decomposition:
- Add the state typedef t_fetch_state (ISSUE, WAIT, HALTED) to the shared registers/opcodes header style, in a new fetch.vh.
- OPCODE_NOP and OPCODE_HALT come from opcodes.vh. The word constant for t_cycle_width comes from businterface.vh.
- No sub-module. A small pc_counter is possible but not worth splitting out; keep it a single module.

Test Plan:
- Zero-wait bus, memory words at 0,4,8 = A,B,C, RESET_PC=0 -> fetch_address 0,4,8 on consecutive cycles; outbound_instruction A,B,C with outbound_pc 0,4,8, one per cycle from cycle 2.
- memory_access_cycle=1 for one cycle while fetch of address 8 is pending without bus_ready -> fetch_read drops for that cycle, one NOP is emitted, address 8 is refetched next and delivered correctly.
- jump=1 to 32'h0000_0103 in the same cycle as bus_ready -> data discarded, NOP out, next fetch_address=32'h0000_0100.
- Fetched word with OPCODE_HALT at pc 12 -> HALT forwarded with outbound_pc=12, then halted=1, fetch_read=0, NOPs forever; a later jump=1 has no effect.
- RESET_PC=32'hFFFF_FFFC, zero-wait bus -> fetches at FFFF_FFFC then 0000_0000.
- reset asserted low while in WAIT with a 3-cycle bus -> all outputs return to reset values immediately; the subsequent bus_ready is ignored; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetchstage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents:
//   OPCODE_NOP / OPCODE_HALT  - 5-bit opcodes held in instruction bits [31:27]
//   NOP_WORD                  - the idle instruction handed to stage 1
//   t_cycle_width             - bus transfer width encoding
//   t_fetch_state             - fetch FSM states (ISSUE, WAIT, HALTED)
//   opcode_of()               - extracts the opcode field of an instruction word
package fetchstage_pkg;

    localparam logic [4:0]  OPCODE_NOP  = 5'h00;
    localparam logic [4:0]  OPCODE_HALT = 5'h1F;
    localparam logic [31:0] NOP_WORD    = {OPCODE_NOP, 27'h0};

    typedef enum logic [1:0] {
        CYCLE_BYTE = 2'd0,
        CYCLE_HALF = 2'd1,
        CYCLE_WORD = 2'd2
    } t_cycle_width;

    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } t_fetch_state;

    function automatic logic [4:0] opcode_of(input logic [31:0] word);
        return word[31:27];
    endfunction

endpackage

// File: rtl/fetchstage_if.sv
// Fetch-side view of the shared memory bus.
// Signals:
//   fetch_read         - read request, held high for the whole outstanding fetch
//   fetch_address      - word-aligned read address
//   fetch_cycle_width  - transfer width, always a word for instruction fetch
//   bus_data_in        - read data returned by the bus
//   bus_ready          - bus_data_in is valid for the outstanding fetch
// Handshake: a fetch is outstanding while fetch_read is high; it completes on
// the first rising edge where fetch_read and bus_ready are both high, and
// bus_data_in is taken on that edge. The requester may drop fetch_read to
// abandon a fetch; a bus_ready seen while fetch_read is low means nothing.
// Modports: master = fetch stage, slave = bus interface.
interface fetchstage_if;
    import fetchstage_pkg::*;

    logic         fetch_read;
    logic [31:0]  fetch_address;
    t_cycle_width fetch_cycle_width;
    logic [31:0]  bus_data_in;
    logic         bus_ready;

    modport master (
        output fetch_read, fetch_address, fetch_cycle_width,
        input  bus_data_in, bus_ready
    );

    modport slave (
        input  fetch_read, fetch_address, fetch_cycle_width,
        output bus_data_in, bus_ready
    );

endinterface

// File: rtl/fetchstage.sv
// Instruction fetch stage. Owns the program counter, issues word reads on the
// shared bus, and hands one registered instruction per completed fetch to
// memory stage 1 (NOP otherwise). Yields the bus while stage 1 runs a memory
// access cycle, redirects on jump, and stops for good after fetching HALT.
// Ports:
//   clock                - rising-edge clock
//   reset                - asynchronous, active-low reset
//   memory_access_cycle  - stage 1 owns the bus this cycle
//   jump, jump_address   - redirect request and target (bits [1:0] ignored)
//   bus                  - fetch side of the shared bus (fetchstage_if.master)
//   outbound_instruction - registered instruction to stage 1
//   outbound_pc          - address of outbound_instruction
//   halted               - high once HALT has been forwarded
//   state                - current FSM state, for observation
module fetchstage
    import fetchstage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               memory_access_cycle,
    input  logic               jump,
    input  logic [31:0]        jump_address,
    fetchstage_if.master       bus,
    output logic [31:0]        outbound_instruction,
    output logic [31:0]        outbound_pc,
    output logic               halted,
    output t_fetch_state       state
);

    t_fetch_state state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         read_q, read_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  opc_q, opc_d;
    logic         halted_q, halted_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  jump_target;
    logic         unused_jump_bits;

    assign pc_plus4         = pc_q + 32'd4;
    assign jump_target      = {jump_address[31:2], 2'b00};
    assign unused_jump_bits = ^jump_address[1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ISSUE;
            pc_q     <= RESET_PC;
            read_q   <= 1'b0;
            addr_q   <= 32'h0;
            instr_q  <= NOP_WORD;
            opc_q    <= 32'h0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            halted_q <= halted_d;
        end
    end

    // In WAIT, fetch_address always equals pc, so pc is the address of the
    // word arriving on bus_data_in.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        read_d   = read_q;
        addr_d   = addr_q;
        instr_d  = NOP_WORD;
        opc_d    = opc_q;
        halted_d = halted_q;

        case (state_q)
            ISSUE: begin
                if (jump) begin
                    pc_d   = jump_target;
                    read_d = 1'b0;
                end else if (memory_access_cycle) begin
                    read_d = 1'b0;
                end else begin
                    read_d  = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (jump) begin
                    // Redirect wins; any data arriving this cycle is dropped.
                    pc_d    = jump_target;
                    read_d  = 1'b0;
                    state_d = ISSUE;
                end else if (bus.bus_ready) begin
                    instr_d = bus.bus_data_in;
                    opc_d   = pc_q;
                    pc_d    = pc_plus4;
                    if (opcode_of(bus.bus_data_in) == OPCODE_HALT) begin
                        read_d   = 1'b0;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else if (!memory_access_cycle) begin
                        // Back-to-back issue keeps a zero-wait bus at one
                        // instruction per cycle.
                        read_d = 1'b1;
                        addr_d = pc_plus4;
                    end else begin
                        read_d  = 1'b0;
                        state_d = ISSUE;
                    end
                end else if (memory_access_cycle) begin
                    // Give the bus to stage 1; pc is kept so the same word
                    // is refetched afterwards.
                    read_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            HALTED: begin
                read_d   = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                read_d  = 1'b0;
                state_d = ISSUE;
            end
        endcase
    end

    assign bus.fetch_read        = read_q;
    assign bus.fetch_address     = addr_q;
    assign bus.fetch_cycle_width = CYCLE_WORD;
    assign outbound_instruction  = instr_q;
    assign outbound_pc           = opc_q;
    assign halted                = halted_q;
    assign state                 = state_q;

endmodule

// File: tb/tb_fetchstage.sv
// Testbench for fetchstage. A table of per-cycle vectors drives the control
// inputs and bus availability and gives the expected registered outputs.
// A bus-level scoreboard queues {address, word} for every completed read
// and checks each non-NOP instruction delivered to stage 1 against it.
// A second instance with RESET_PC = FFFF_FFFC checks the pc wrap, and a
// hand-written sequence covers reset in the middle of a fetch.
module tb_fetchstage;
    import fetchstage_pkg::*;

    localparam logic [31:0] WORD_A    = {5'h01, 27'h000_0AAA};
    localparam logic [31:0] WORD_B    = {5'h03, 27'h000_0BBB};
    localparam logic [31:0] WORD_C    = {5'h04, 27'h000_0CCC};
    localparam logic [31:0] HALT_WORD = {OPCODE_HALT, 27'h000_0123};

    // clock / reset
    logic clock;
    logic reset;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // stimulus
    logic        mac;
    logic        jump;
    logic [31:0] jaddr;
    logic        rdy_en;
    logic        force_ready;

    // DUT 0: RESET_PC = 0
    fetchstage_if bus0();
    logic [31:0]  instr0, pc0;
    logic         halted0;
    t_fetch_state state0;

    // DUT 1: RESET_PC = FFFF_FFFC, zero-wait bus, no jumps or memory cycles
    fetchstage_if bus1();
    logic [31:0]  instr1, pc1;
    logic         halted1;
    t_fetch_state state1;

    // Instruction memory model
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return WORD_A;
            32'h0000_0004: return WORD_B;
            32'h0000_0008: return WORD_C;
            32'h0000_000C: return HALT_WORD;
            default:       return {5'h02, a[26:0]};
        endcase
    endfunction

    assign bus0.bus_ready   = (bus0.fetch_read & rdy_en) | force_ready;
    assign bus0.bus_data_in = mem_word(bus0.fetch_address);
    assign bus1.bus_ready   = bus1.fetch_read;
    assign bus1.bus_data_in = mem_word(bus1.fetch_address);

    fetchstage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clock               (clock),
        .reset               (reset),
        .memory_access_cycle (mac),
        .jump                (jump),
        .jump_address        (jaddr),
        .bus                 (bus0),
        .outbound_instruction(instr0),
        .outbound_pc         (pc0),
        .halted              (halted0),
        .state               (state0)
    );

    fetchstage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clock               (clock),
        .reset               (reset),
        .memory_access_cycle (1'b0),
        .jump                (1'b0),
        .jump_address        (32'h0),
        .bus                 (bus1),
        .outbound_instruction(instr1),
        .outbound_pc         (pc1),
        .halted              (halted1),
        .state               (state1)
    );

    // counters and compare helper
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // scoreboard
    logic [63:0] exp_q[$];

    // Sampled mid-cycle: a read completes on the next edge unless jump drops it.
    always @(negedge clock) begin
        if (reset && bus0.fetch_read && bus0.bus_ready && !jump)
            exp_q.push_back({bus0.fetch_address, bus0.bus_data_in});
    end

    always @(posedge clock) begin
        logic [63:0] item;
        #1;
        if (reset && opcode_of(instr0) != OPCODE_NOP) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected no delivery", pc0, instr0);
            end else begin
                item = exp_q.pop_front();
                check("sb_pc", pc0, item[63:32]);
                check("sb_instr", instr0, item[31:0]);
            end
        end
    end

    // vector table
    typedef struct {
        logic        mac;
        logic        jump;
        logic [31:0] jaddr;
        logic        rdy;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_halted;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic j, input logic [31:0] ja,
                                input logic r, input logic er, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] ep, input logic eh);
        vec_t v;
        v.mac = m; v.jump = j; v.jaddr = ja; v.rdy = r;
        v.exp_read = er; v.exp_addr = ea; v.exp_instr = ei; v.exp_pc = ep; v.exp_halted = eh;
        return v;
    endfunction

    vec_t vecs[17];
    logic [31:0] exp1_addr[3];
    logic [31:0] exp1_instr[3];
    logic [31:0] exp1_pc[3];

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        //             mac jmp jaddr          rdy  read addr          instr            pc             halted
        vecs[0]  = mk(0, 0, 32'h0,          1,   1, 32'h0,        NOP_WORD,          32'h0,   0);
        vecs[1]  = mk(0, 0, 32'h0,          1,   1, 32'h4,        WORD_A,            32'h0,   0);
        vecs[2]  = mk(0, 0, 32'h0,          1,   1, 32'h8,        WORD_B,            32'h4,   0);
        vecs[3]  = mk(0, 0, 32'h0,          0,   1, 32'h8,        NOP_WORD,          32'h4,   0);
        vecs[4]  = mk(1, 0, 32'h0,          0,   0, 32'h8,        NOP_WORD,          32'h4,   0);
        vecs[5]  = mk(1, 1, 32'h0000_000B,  1,   0, 32'h8,        NOP_WORD,          32'h4,   0);
        vecs[6]  = mk(0, 0, 32'h0,          1,   1, 32'h8,        NOP_WORD,          32'h4,   0);
        vecs[7]  = mk(0, 0, 32'h0,          1,   1, 32'hC,        WORD_C,            32'h8,   0);
        vecs[8]  = mk(0, 1, 32'h0000_0103,  1,   0, 32'hC,        NOP_WORD,          32'h8,   0);
        vecs[9]  = mk(0, 0, 32'h0,          1,   1, 32'h100,      NOP_WORD,          32'h8,   0);
        vecs[10] = mk(0, 0, 32'h0,          1,   1, 32'h104,      {5'h02, 27'h100},  32'h100, 0);
        vecs[11] = mk(0, 1, 32'h0000_000E,  1,   0, 32'h104,      NOP_WORD,          32'h100, 0);
        vecs[12] = mk(0, 0, 32'h0,          1,   1, 32'hC,        NOP_WORD,          32'h100, 0);
        vecs[13] = mk(0, 0, 32'h0,          1,   0, 32'hC,        HALT_WORD,         32'hC,   1);
        vecs[14] = mk(0, 1, 32'h0000_0200,  1,   0, 32'hC,        NOP_WORD,          32'hC,   1);
        vecs[15] = mk(1, 0, 32'h0,          1,   0, 32'hC,        NOP_WORD,          32'hC,   1);
        vecs[16] = mk(0, 0, 32'h0,          1,   0, 32'hC,        NOP_WORD,          32'hC,   1);

        exp1_addr[0] = 32'hFFFF_FFFC; exp1_instr[0] = NOP_WORD;          exp1_pc[0] = 32'h0;
        exp1_addr[1] = 32'h0000_0000; exp1_instr[1] = {5'h02, 27'h7FF_FFFC}; exp1_pc[1] = 32'hFFFF_FFFC;
        exp1_addr[2] = 32'h0000_0004; exp1_instr[2] = WORD_A;            exp1_pc[2] = 32'h0;

        reset = 1'b0; mac = 1'b0; jump = 1'b0; jaddr = 32'h0;
        rdy_en = 1'b1; force_ready = 1'b0;
        tick();
        tick();

        check("rst_read", 32'(bus0.fetch_read), 32'h0);
        check("rst_addr", bus0.fetch_address, 32'h0);
        check("rst_instr", instr0, NOP_WORD);
        check("rst_pc", pc0, 32'h0);
        check("rst_halted", 32'(halted0), 32'h0);
        check("rst_state", 32'(state0), 32'(ISSUE));
        check("rst_width", 32'(bus0.fetch_cycle_width), 32'(CYCLE_WORD));
        check("rst1_addr", bus1.fetch_address, 32'h0);

        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            mac    = vecs[i].mac;
            jump   = vecs[i].jump;
            jaddr  = vecs[i].jaddr;
            rdy_en = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_read", i), 32'(bus0.fetch_read), 32'(vecs[i].exp_read));
            check($sformatf("v%0d_addr", i), bus0.fetch_address, vecs[i].exp_addr);
            check($sformatf("v%0d_instr", i), instr0, vecs[i].exp_instr);
            check($sformatf("v%0d_pc", i), pc0, vecs[i].exp_pc);
            check($sformatf("v%0d_halted", i), 32'(halted0), 32'(vecs[i].exp_halted));
            if (i < 3) begin
                check($sformatf("wrap%0d_addr", i), bus1.fetch_address, exp1_addr[i]);
                check($sformatf("wrap%0d_instr", i), instr1, exp1_instr[i]);
                check($sformatf("wrap%0d_pc", i), pc1, exp1_pc[i]);
            end
        end
        check("halt_state", 32'(state0), 32'(HALTED));
        check("halt_width", 32'(bus0.fetch_cycle_width), 32'(CYCLE_WORD));

        // Reset while a fetch of address 8 is waiting on a slow bus.
        mac = 1'b0; jump = 1'b0; jaddr = 32'h0; rdy_en = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();                                     // issue 0
        tick();                                     // A, issue 4
        tick();                                     // B, issue 8
        check("mid_instr", instr0, WORD_B);
        rdy_en = 1'b0;
        tick();                                     // wait state 1
        tick();                                     // wait state 2
        check("mid_wait_read", 32'(bus0.fetch_read), 32'h1);
        check("mid_wait_addr", bus0.fetch_address, 32'h8);
        check("mid_wait_pc", pc0, 32'h4);
        #2;
        reset = 1'b0;
        #1;
        check("async_read", 32'(bus0.fetch_read), 32'h0);
        check("async_addr", bus0.fetch_address, 32'h0);
        check("async_instr", instr0, NOP_WORD);
        check("async_pc", pc0, 32'h0);
        check("async_halted", 32'(halted0), 32'h0);
        check("async_state", 32'(state0), 32'(ISSUE));
        tick();
        // The bus finally answers the abandoned read.
        force_ready = 1'b1;
        reset = 1'b1;
        tick();
        check("late_rdy_instr", instr0, NOP_WORD);
        check("late_rdy_read", 32'(bus0.fetch_read), 32'h1);
        check("late_rdy_addr", bus0.fetch_address, 32'h0);
        force_ready = 1'b0;
        rdy_en = 1'b1;
        tick();
        check("restart_instr", instr0, WORD_A);
        check("restart_pc", pc0, 32'h0);
        check("restart_addr", bus0.fetch_address, 32'h4);

        rdy_en = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
